// File: rtl/scroll_ctrl_if.sv
// Board-side bundle for the six-character scroller: push-buttons and switches in,
// character codes and status out. The bench drives through master; the design uses slave.
interface scroll_ctrl_if;
    logic [3:0]  KEY;
    logic [9:0]  SW;
    logic [23:0] codes;
    logic        step;
    logic [1:0]  mode;
    logic        dir;

    modport master (output KEY, SW, input codes, step, mode, dir);
    modport slave  (input KEY, SW, output codes, step, mode, dir);
endinterface

// File: rtl/scroll_ctrl.sv
// Six-slot character scroller with run/pause/load control and a switchable-rate prescaler.
// Define SCROLL_DIR_EN to enable the KEY[3] direction toggle; otherwise dir is fixed at 0.

module scroll_key #(
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key,
    output logic press
);
    localparam int DW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

    logic [1:0]    sync_ff;
    logic          level;
    logic [DW-1:0] db_cnt;

    // A new level is accepted only after DB_CYCLES consecutive differing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_ff <= 2'b11;
            level   <= 1'b1;
            db_cnt  <= '0;
            press   <= 1'b0;
        end else begin
            sync_ff <= {sync_ff[0], key};
            press   <= 1'b0;
            if (sync_ff[1] == level) begin
                db_cnt <= '0;
            end else if (db_cnt == DW'(DB_CYCLES - 1)) begin
                level  <= sync_ff[1];
                db_cnt <= '0;
                press  <= ~sync_ff[1];
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end
endmodule

module scroll_ctrl #(
    parameter int CLK_HZ    = 50_000_000,
    parameter int DB_CYCLES = 1_000_000
) (
    input logic           CLOCK_50,
    scroll_ctrl_if.slave  bus
);
    localparam int CW = $clog2(2 * CLK_HZ);

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        PAUSE = 2'b01,
        LOAD  = 2'b10
    } state_t;

    state_t        state, state_next;
    logic          rst_n;
    logic          run_press;
    logic          wr_press;
    logic          tick;
    logic          dir_q;
    logic [CW-1:0] pre_cnt;
    logic [CW-1:0] limit_m1;
    logic [23:0]   codes_q;
    logic          step_q;

    assign rst_n = bus.KEY[0];

    scroll_key #(.DB_CYCLES(DB_CYCLES)) u_key_run (
        .clk(CLOCK_50), .rst_n(rst_n), .key(bus.KEY[1]), .press(run_press)
    );

    scroll_key #(.DB_CYCLES(DB_CYCLES)) u_key_wr (
        .clk(CLOCK_50), .rst_n(rst_n), .key(bus.KEY[2]), .press(wr_press)
    );

`ifdef SCROLL_DIR_EN
    logic dir_press;

    scroll_key #(.DB_CYCLES(DB_CYCLES)) u_key_dir (
        .clk(CLOCK_50), .rst_n(rst_n), .key(bus.KEY[3]), .press(dir_press)
    );

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            dir_q <= 1'b0;
        end else if (dir_press) begin
            dir_q <= ~dir_q;
        end
    end
`else
    logic unused_key3;
    assign unused_key3 = bus.KEY[3];
    assign dir_q       = 1'b0;
`endif

    always_comb begin
        limit_m1 = CW'(CLK_HZ - 1);
        case (bus.SW[9:8])
            2'b00:   limit_m1 = CW'(CLK_HZ - 1);
            2'b01:   limit_m1 = CW'(CLK_HZ / 2 - 1);
            2'b10:   limit_m1 = CW'(CLK_HZ / 4 - 1);
            default: limit_m1 = CW'(2 * CLK_HZ - 1);
        endcase
    end

    // ">=" rather than "==" so a speed change that strands the count above the new limit ticks at once.
    assign tick = (state == RUN) && (pre_cnt >= limit_m1);

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (bus.SW[7]) begin
            state_next = LOAD;
        end else begin
            case (state)
                RUN:     if (run_press) state_next = PAUSE;
                PAUSE:   if (run_press) state_next = RUN;
                LOAD:    state_next = PAUSE;
                default: state_next = RUN;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
        end else if (state == LOAD) begin
            pre_cnt <= '0;
        end else if (state == RUN) begin
            pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
        end
    end

    // Rotation and slot writes never coincide: ticks only occur outside LOAD.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            codes_q <= 24'h000DE1;
            step_q  <= 1'b0;
        end else begin
            step_q <= tick;
            if (tick) begin
                if (dir_q) begin
                    codes_q <= {codes_q[3:0], codes_q[23:4]};
                end else begin
                    codes_q <= {codes_q[19:0], codes_q[23:20]};
                end
            end else if ((state == LOAD) && wr_press && (bus.SW[6:4] < 3'd6)) begin
                codes_q[{bus.SW[6:4], 2'b00} +: 4] <= bus.SW[3:0];
            end
        end
    end

    assign bus.codes = codes_q;
    assign bus.step  = step_q;
    assign bus.mode  = state;
    assign bus.dir   = dir_q;
endmodule

// File: tb/tb_scroll_ctrl.sv
// Directed bench for scroll_ctrl at CLK_HZ=8, DB_CYCLES=2; a button press takes
// effect four edges after the key goes low.
module tb_scroll_ctrl;
    logic clk;
    int   errors;
    int   checks;

`ifdef SCROLL_DIR_EN
    localparam logic DIR_AFTER_PRESS = 1'b1;
`else
    localparam logic DIR_AFTER_PRESS = 1'b0;
`endif

    scroll_ctrl_if bus ();

    scroll_ctrl #(.CLK_HZ(8), .DB_CYCLES(2)) dut (
        .CLOCK_50(clk),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Holds the key low for three cycles, then waits until the press has been acted on.
    task automatic applyStimulus(input int key_idx);
        bus.KEY[key_idx] = 1'b0;
        waitCycles(3);
        bus.KEY[key_idx] = 1'b1;
        waitCycles(2);
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        bus.KEY = 4'b1110;
        bus.SW  = 10'd0;
        waitCycles(3);
        checkOutput("reset_codes", bus.codes, 24'h000DE1);
        checkOutput("reset_mode", {22'd0, bus.mode}, 24'd0);
        checkOutput("reset_step", {23'd0, bus.step}, 24'd0);
        checkOutput("reset_dir", {23'd0, bus.dir}, 24'd0);

        bus.KEY[0] = 1'b1;
        waitCycles(7);
        checkOutput("pre_first_step", {23'd0, bus.step}, 24'd0);
        checkOutput("pre_first_codes", bus.codes, 24'h000DE1);
        waitCycles(1);
        checkOutput("first_step", {23'd0, bus.step}, 24'd1);
        checkOutput("first_codes", bus.codes, 24'h00DE10);
        waitCycles(1);
        checkOutput("step_one_cycle", {23'd0, bus.step}, 24'd0);
        waitCycles(7);
        checkOutput("second_step", {23'd0, bus.step}, 24'd1);
        checkOutput("second_codes", bus.codes, 24'h0DE100);

        bus.SW[9:8] = 2'b10;
        waitCycles(2);
        checkOutput("fast_step1", {23'd0, bus.step}, 24'd1);
        checkOutput("fast_codes1", bus.codes, 24'hDE1000);
        waitCycles(2);
        checkOutput("fast_step2", {23'd0, bus.step}, 24'd1);
        checkOutput("fast_codes2", bus.codes, 24'hE1000D);

        bus.SW[9:8] = 2'b00;
        waitCycles(5);
        checkOutput("count5_no_step", {23'd0, bus.step}, 24'd0);
        bus.SW[9:8] = 2'b11;
        waitCycles(10);
        checkOutput("slow_no_step", {23'd0, bus.step}, 24'd0);
        waitCycles(1);
        checkOutput("slow_step", {23'd0, bus.step}, 24'd1);
        checkOutput("slow_codes", bus.codes, 24'h1000DE);

        bus.SW[9:8] = 2'b00;
        waitCycles(5);
        bus.SW[9:8] = 2'b10;
        waitCycles(1);
        checkOutput("overlimit_step", {23'd0, bus.step}, 24'd1);
        checkOutput("overlimit_codes", bus.codes, 24'h000DE1);
        bus.SW[9:8] = 2'b00;

        applyStimulus(1);
        checkOutput("pause_mode", {22'd0, bus.mode}, 24'd1);
        checkOutput("pause_codes", bus.codes, 24'h000DE1);
        waitCycles(20);
        checkOutput("pause_frozen_codes", bus.codes, 24'h000DE1);
        checkOutput("pause_frozen_step", {23'd0, bus.step}, 24'd0);
        applyStimulus(1);
        checkOutput("resume_mode", {22'd0, bus.mode}, 24'd0);
        waitCycles(2);
        checkOutput("resume_no_step", {23'd0, bus.step}, 24'd0);
        waitCycles(1);
        checkOutput("resume_held_count", {23'd0, bus.step}, 24'd1);
        checkOutput("resume_codes", bus.codes, 24'h00DE10);

        bus.SW[7:0] = {1'b1, 3'd3, 4'hA};
        waitCycles(1);
        checkOutput("load_mode", {22'd0, bus.mode}, 24'd2);
        applyStimulus(2);
        checkOutput("load_slot3", bus.codes, 24'h00AE10);
        bus.SW[6:4] = 3'd7;
        applyStimulus(2);
        checkOutput("load_slot7_ignored", bus.codes, 24'h00AE10);
        bus.SW[6:4] = 3'd6;
        applyStimulus(2);
        checkOutput("load_slot6_ignored", bus.codes, 24'h00AE10);
        bus.SW[6:0] = {3'd0, 4'h5};
        applyStimulus(2);
        checkOutput("load_slot0", bus.codes, 24'h00AE15);
        bus.SW[7] = 1'b0;
        waitCycles(1);
        checkOutput("load_exit_mode", {22'd0, bus.mode}, 24'd1);
        bus.SW[6:0] = {3'd1, 4'hF};
        applyStimulus(2);
        checkOutput("write_outside_load", bus.codes, 24'h00AE15);

        applyStimulus(1);
        checkOutput("run_after_load", {22'd0, bus.mode}, 24'd0);
        waitCycles(7);
        checkOutput("load_cleared_count", {23'd0, bus.step}, 24'd0);
        waitCycles(1);
        checkOutput("post_load_step", {23'd0, bus.step}, 24'd1);
        checkOutput("post_load_codes", bus.codes, 24'h0AE150);

        waitCycles(3);
        bus.KEY[1] = 1'b0;
        waitCycles(3);
        bus.KEY[1] = 1'b1;
        waitCycles(1);
        checkOutput("coincide_pre_mode", {22'd0, bus.mode}, 24'd0);
        waitCycles(1);
        checkOutput("coincide_step", {23'd0, bus.step}, 24'd1);
        checkOutput("coincide_codes", bus.codes, 24'hAE1500);
        checkOutput("coincide_mode", {22'd0, bus.mode}, 24'd1);
        waitCycles(5);
        checkOutput("coincide_frozen", bus.codes, 24'hAE1500);

        applyStimulus(1);
        waitCycles(8);
        checkOutput("prereset_step", {23'd0, bus.step}, 24'd1);
        checkOutput("prereset_codes", bus.codes, 24'hE1500A);
        #2;
        bus.KEY[0] = 1'b0;
        #1;
        checkOutput("async_reset_codes", bus.codes, 24'h000DE1);
        checkOutput("async_reset_mode", {22'd0, bus.mode}, 24'd0);
        checkOutput("async_reset_step", {23'd0, bus.step}, 24'd0);
        waitCycles(2);
        bus.KEY[0] = 1'b1;
        waitCycles(7);
        checkOutput("rerelease_no_step", {23'd0, bus.step}, 24'd0);
        waitCycles(1);
        checkOutput("rerelease_step", {23'd0, bus.step}, 24'd1);
        checkOutput("rerelease_codes", bus.codes, 24'h00DE10);

        applyStimulus(3);
        checkOutput("dir_press", {23'd0, bus.dir}, {23'd0, DIR_AFTER_PRESS});
        waitCycles(2);
        checkOutput("dir_no_step", {23'd0, bus.step}, 24'd0);
        waitCycles(1);
        checkOutput("dir_step", {23'd0, bus.step}, 24'd1);
        checkOutput("dir_codes", bus.codes, DIR_AFTER_PRESS ? 24'h000DE1 : 24'h0DE100);
        bus.KEY[3] = 1'b0;
        waitCycles(1);
        bus.KEY[3] = 1'b1;
        waitCycles(5);
        checkOutput("dir_glitch", {23'd0, bus.dir}, {23'd0, DIR_AFTER_PRESS});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/scroll_ctrl.md
SCROLL_CTRL -- requirements
Module: scroll_ctrl

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50_000_000: clock cycles per 1 s base step period.
REQ-002 SHALL have parameter DB_CYCLES, default 1_000_000: cycles a button level must be stable before it is accepted (20 ms).
REQ-003 SHALL have port CLOCK_50  in  1: the single clock; all state on its rising edge.
REQ-004 SHALL have port KEY  in  4: KEY[0] is the asynchronous, active-low reset; KEY[1] is run/pause (active-low); KEY[2] is write strobe (active-low); KEY[3] is direction toggle (active-low).
REQ-005 SHALL have port SW  in  10: SW[3:0] char code; SW[6:4] slot index; SW[7] load mode; SW[9:8] speed select.
REQ-006 SHALL have port codes  out  24: six 4-bit character codes, slot 5 in [23:20] down to slot 0 in [3:0], for the downstream six-digit decoder.
REQ-007 SHALL have port step  out  1: one-cycle pulse in the cycle after codes rotates.
REQ-008 SHALL have port mode  out  2: 00 RUN, 01 PAUSE, 10 LOAD.
REQ-009 SHALL have port dir  out  1: 0 left rotation, 1 right rotation.

Function
REQ-010 KEY[3:1] SHALL each pass through a 2-FF synchronizer, then a debouncer that accepts a new level only after DB_CYCLES consecutive equal samples.
REQ-011 A press event SHALL be a one-cycle pulse on a debounced 1->0 transition; release SHALL generate no event.
REQ-012 Prescaler SHALL count 0..LIMIT-1 and assert an internal tick when it reaches LIMIT-1, then wrap to 0; LIMIT = CLK_HZ (SW[9:8]=00), CLK_HZ/2 (01), CLK_HZ/4 (10), 2*CLK_HZ (11).
REQ-013 If SW[9:8] changes so that count >= LIMIT-1, the prescaler SHALL tick on the next cycle and wrap to 0 (no long wrap-around).
REQ-014 Prescaler SHALL advance only in RUN; in PAUSE it SHALL hold its value; in LOAD it SHALL be held at 0.
REQ-015 On tick with dir=0, codes SHALL rotate left: slot5<=slot4, slot4<=slot3, ..., slot1<=slot0, slot0<=slot5.
REQ-016 On tick with dir=1, codes SHALL rotate right: slot0<=slot1, ..., slot4<=slot5, slot5<=slot0.
REQ-017 step SHALL be high exactly in the cycle following each tick; latency tick->codes update is 1 cycle.
REQ-018 FSM: RUN --KEY[1] press--> PAUSE; PAUSE --KEY[1] press--> RUN; any state with SW[7]=1 --> LOAD; LOAD with SW[7]=0 --> PAUSE.
REQ-019 SW[7]=1 SHALL take priority over a KEY[1] press in the same cycle.
REQ-020 In LOAD, a KEY[2] press SHALL write SW[3:0] into slot SW[6:4] in the next cycle; slot indices 6 and 7 SHALL be ignored (no change).
REQ-021 KEY[2] presses outside LOAD SHALL be ignored.
REQ-022 Tick and KEY[1] press in the same cycle SHALL complete the rotation, then enter PAUSE.
REQ-023 codes SHALL never change except by rotation (REQ-015/016), LOAD write (REQ-020), or reset.

Reset
REQ-024 KEY[0]=0 SHALL immediately and asynchronously set: codes=24'h000DE1, prescaler=0, mode=RUN, dir=0, step=0, synchronizer/debouncer state=released (1), counts=0.
REQ-025 Reset asserted mid-rotation or mid-debounce SHALL discard the pending operation; release SHALL be synchronous to CLOCK_50, first tick CLK_HZ cycles later (SW[9:8]=00).

Configuration
REQ-026 With macro SCROLL_DIR_EN defined, a KEY[3] press SHALL toggle dir in any mode, taking effect on the next tick.
REQ-027 Without SCROLL_DIR_EN, KEY[3] SHALL be ignored, its synchronizer/debouncer SHALL be absent, and dir SHALL be tied to 0.

Verification (CLK_HZ=8, DB_CYCLES=2)
REQ-028 Reset release, SW=0 -> step every 8 cycles; codes 000DE1 -> 00DE10 -> 0DE100.
REQ-029 SW[9:8]=10 in RUN -> step every 2 cycles; switch to 11 with count=5 -> next step after 11 cycles.
REQ-030 KEY[1] pulse held 3 cycles -> mode=01, codes/prescaler frozen; second press -> mode=00, resumes from held count.
REQ-031 SW[7]=1, SW[6:4]=3, SW[3:0]=A, KEY[2] press -> codes=00ADE1; SW[6:4]=7 press -> unchanged; SW[7]=0 -> mode=01.
REQ-032 SCROLL_DIR_EN defined, KEY[3] press -> dir=1, codes 000DE1 -> 1000DE on the next step; KEY[3] held 1 cycle (glitch) -> no toggle.
REQ-033 KEY[0] low mid-period after 3 rotations -> codes=000DE1, mode=00, step=0 within the same cycle.
